bus_rr_arbiter: RTL and testbench

- Round-robin bus arbiter for the four bus masters (m0..m3) of the shared bus.
- Drives the active-low grant lines consumed by the bus master multiplexer, so exactly one master owns the slave-side bus in every cycle.
- Adds a bounded-tenure preemption: a master holding the bus for MAX_HOLD consecutive cycles while others wait is forced off.
- Sits beside the master mux in the bus top level; the masters are the CPU IF/MEM ports and the DMA/peripheral masters.

---
 rtl/bus_rr_arbiter_if.sv | 26 ++
 rtl/bus_rr_arbiter.sv | 90 +++++++++
 tb/tb_bus_rr_arbiter.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/bus_rr_arbiter_if.sv
// Request/grant bundle between the four bus masters and the round-robin arbiter.
// All req_/grnt_ lines are active-low; owner/preempt are status for the bus top.
interface bus_rr_arbiter_if;
    logic       m0_req_;
    logic       m1_req_;
    logic       m2_req_;
    logic       m3_req_;
    logic       m0_grnt_;
    logic       m1_grnt_;
    logic       m2_grnt_;
    logic       m3_grnt_;
    logic [1:0] owner;
    logic       preempt;

    // Master side: raises requests, observes grants
    modport master (
        output m0_req_, m1_req_, m2_req_, m3_req_,
        input  m0_grnt_, m1_grnt_, m2_grnt_, m3_grnt_, owner, preempt
    );

    // Arbiter side: samples requests, drives grants
    modport slave (
        input  m0_req_, m1_req_, m2_req_, m3_req_,
        output m0_grnt_, m1_grnt_, m2_grnt_, m3_grnt_, owner, preempt
    );
endinterface

// File: rtl/bus_rr_arbiter.sv
// Four-master round-robin bus arbiter with bounded-tenure preemption.
// The owner register alone decides the grant lines, so exactly one grant is
// low in every cycle and the bus parks with the last owner when idle.
module bus_rr_arbiter #(
    parameter int HOLD_W   = 8,
    parameter int MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             reset_,
    bus_rr_arbiter_if.slave  bus
);

    // Compare value for the tenure counter; unused when preemption is off
    localparam int unsigned           LIM      = (MAX_HOLD == 0) ? 0 : MAX_HOLD - 1;
    localparam logic [HOLD_W-1:0]     HOLD_LIM = LIM[HOLD_W-1:0];
    localparam logic [HOLD_W-1:0]     HOLD_MAX = {HOLD_W{1'b1}};

    logic [1:0]        owner_q, owner_n;
    logic [HOLD_W-1:0] hold_cnt, hold_n;
    logic              preempt_r, preempt_n;

    logic [3:0]        req;
    logic [3:0]        grnt_n;
    logic [1:0]        scan_idx;
    logic [1:0]        cand;
    logic              scan_hit;
    logic              own_req;
    logic              contention;
    logic              preempt_hit;

    // Active-high view of the requests
    assign req = ~{bus.m3_req_, bus.m2_req_, bus.m1_req_, bus.m0_req_};

    // Find the first other requester starting after the owner, wrapping
    always_comb begin
        scan_idx = owner_q;
        scan_hit = 1'b0;
        cand     = owner_q;
        for (int k = 1; k < 4; k++) begin
            cand = owner_q + 2'(k);
            if (!scan_hit && req[cand]) begin
                scan_idx = cand;
                scan_hit = 1'b1;
            end
        end
    end

    assign own_req     = req[owner_q];
    assign contention  = own_req && scan_hit;
    assign preempt_hit = (MAX_HOLD != 0) && contention && (hold_cnt == HOLD_LIM);

    // Next owner, tenure count and preempt pulse
    always_comb begin
        owner_n   = owner_q;
        hold_n    = '0;
        preempt_n = 1'b0;
        if (!own_req && scan_hit) begin
            // voluntary release wins over any preempt condition
            owner_n = scan_idx;
        end else if (preempt_hit) begin
            owner_n   = scan_idx;
            preempt_n = 1'b1;
        end else if (contention) begin
            hold_n = (hold_cnt == HOLD_MAX) ? hold_cnt : hold_cnt + 1'b1;
        end
    end

    // State registers; master 0 parks on the bus out of reset
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            owner_q   <= 2'd0;
            hold_cnt  <= '0;
            preempt_r <= 1'b0;
        end else begin
            owner_q   <= owner_n;
            hold_cnt  <= hold_n;
            preempt_r <= preempt_n;
        end
    end

    // One-hot-low grant decode from the owner register only
    assign grnt_n       = ~(4'b0001 << owner_q);
    assign bus.m0_grnt_ = grnt_n[0];
    assign bus.m1_grnt_ = grnt_n[1];
    assign bus.m2_grnt_ = grnt_n[2];
    assign bus.m3_grnt_ = grnt_n[3];
    assign bus.owner    = owner_q;
    assign bus.preempt  = preempt_r;

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Bench for bus_rr_arbiter: three instances (MAX_HOLD=16, preemption off,
// HOLD_W=4/MAX_HOLD=15) share one request stimulus and are each tracked by
// a cycle-level behavioural model; directed literal checks pin the model.
module tb_bus_rr_arbiter;
    logic       clk = 1'b0;
    logic       reset_ = 1'b0;
    logic [3:0] req_n = 4'hF;   // bit i = mi_req_

    int n_checks = 0;
    int n_fail   = 0;
    int b_pre_seen = 0;

    always #5 clk = ~clk;

    bus_rr_arbiter_if ifa();
    bus_rr_arbiter_if ifb();
    bus_rr_arbiter_if ifc();

    assign {ifa.m3_req_, ifa.m2_req_, ifa.m1_req_, ifa.m0_req_} = req_n;
    assign {ifb.m3_req_, ifb.m2_req_, ifb.m1_req_, ifb.m0_req_} = req_n;
    assign {ifc.m3_req_, ifc.m2_req_, ifc.m1_req_, ifc.m0_req_} = req_n;

    bus_rr_arbiter #(.HOLD_W(8), .MAX_HOLD(16)) dut_a (.clk(clk), .reset_(reset_), .bus(ifa));
    bus_rr_arbiter #(.HOLD_W(8), .MAX_HOLD(0))  dut_b (.clk(clk), .reset_(reset_), .bus(ifb));
    bus_rr_arbiter #(.HOLD_W(4), .MAX_HOLD(15)) dut_c (.clk(clk), .reset_(reset_), .bus(ifc));

    // Flattened DUT observations per instance
    logic [1:0] d_own [3];
    logic [3:0] d_gnt [3];
    logic       d_pre [3];
    assign d_own[0] = ifa.owner;
    assign d_own[1] = ifb.owner;
    assign d_own[2] = ifc.owner;
    assign d_gnt[0] = {ifa.m3_grnt_, ifa.m2_grnt_, ifa.m1_grnt_, ifa.m0_grnt_};
    assign d_gnt[1] = {ifb.m3_grnt_, ifb.m2_grnt_, ifb.m1_grnt_, ifb.m0_grnt_};
    assign d_gnt[2] = {ifc.m3_grnt_, ifc.m2_grnt_, ifc.m1_grnt_, ifc.m0_grnt_};
    assign d_pre[0] = ifa.preempt;
    assign d_pre[1] = ifb.preempt;
    assign d_pre[2] = ifc.preempt;

    // Behavioural model state: integer tenure, no width limits
    int m_own [3];
    int m_ten [3];
    int m_pre [3];
    int mh    [3] = '{16, 0, 15};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] gnt_of(input int o);
        logic [3:0] g;
        g = 4'hF;
        g[o] = 1'b0;
        return g;
    endfunction

    // Model advance: who owns the bus after this edge, from the rules
    task automatic model_step(input int i);
        int o, pick, others;
        bit own_req;
        o = m_own[i];
        own_req = (req_n[o] == 1'b0);
        others = 0;
        pick = o;
        for (int k = 3; k >= 1; k--) begin
            if (req_n[(o + k) % 4] == 1'b0) begin
                others++;
                pick = (o + k) % 4;   // descending loop leaves the nearest one
            end
        end
        m_pre[i] = 0;
        if (others == 0) begin
            m_ten[i] = 0;
        end else if (!own_req) begin
            m_own[i] = pick;
            m_ten[i] = 0;
        end else if (mh[i] != 0 && m_ten[i] + 1 == mh[i]) begin
            m_own[i] = pick;
            m_ten[i] = 0;
            m_pre[i] = 1;
        end else begin
            m_ten[i] = m_ten[i] + 1;
        end
    endtask

    always @(posedge clk or negedge reset_) begin
        for (int i = 0; i < 3; i++) begin
            if (!reset_) begin
                m_own[i] = 0;
                m_ten[i] = 0;
                m_pre[i] = 0;
            end else begin
                model_step(i);
            end
        end
    end

    // Per-cycle comparison of every instance against the model
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            check($sformatf("owner[%0d]", i), 32'(d_own[i]), 32'(m_own[i]));
            check($sformatf("grnt[%0d]", i), 32'(d_gnt[i]), 32'(gnt_of(m_own[i])));
            check($sformatf("preempt[%0d]", i), 32'(d_pre[i]), 32'(m_pre[i]));
            check($sformatf("onehot[%0d]", i), 32'($countones(~d_gnt[i])), 32'd1);
        end
        if (d_pre[1] !== 1'b0) b_pre_seen++;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset/park
        #1;
        check("rst_grnt_a", 32'(d_gnt[0]), 32'h0000000E);
        check("rst_owner_a", 32'(d_own[0]), 32'd0);
        check("rst_pre_a", 32'(d_pre[0]), 32'd0);
        step(2);
        @(negedge clk) reset_ = 1'b1;
        step(10);
        check("park_owner", 32'(d_own[0]), 32'd0);
        check("park_grnt", 32'(d_gnt[0]), 32'h0000000E);

        // Round-robin walk 0->1->2->3->0
        req_n = 4'b1110; step(2);
        req_n = 4'b0000; step(3);
        check("rr_hold0", 32'(d_own[0]), 32'd0);
        req_n = 4'b0001; step(1);
        check("rr_to1", 32'(d_own[0]), 32'd1);
        req_n = 4'b0011; step(1);
        check("rr_to2", 32'(d_own[0]), 32'd2);
        req_n = 4'b0111; step(1);
        check("rr_to3", 32'(d_own[0]), 32'd3);
        req_n = 4'b1110; step(1);
        check("rr_to0", 32'(d_own[0]), 32'd0);
        check("rr_grnt0", 32'(d_gnt[0]), 32'h0000000E);

        // Wrap scan: owner 3, m1+m2 request, m0 idle -> 1
        req_n = 4'b0111; step(1);
        check("wrap_own3", 32'(d_own[0]), 32'd3);
        req_n = 4'b1001; step(1);
        check("wrap_to1", 32'(d_own[0]), 32'd1);

        // Preemption: m2 owns, m0 contends
        req_n = 4'b1011; step(1);
        check("pre_own2", 32'(d_own[0]), 32'd2);
        req_n = 4'b1010; step(15);
        check("pre15_a_holds", 32'(d_own[0]), 32'd2);
        check("pre15_c_switch", 32'(d_own[2]), 32'd0);
        check("pre15_c_pulse", 32'(d_pre[2]), 32'd1);
        step(1);
        check("pre16_a_switch", 32'(d_own[0]), 32'd0);
        check("pre16_a_pulse", 32'(d_pre[0]), 32'd1);
        check("pre16_c_pulse_gone", 32'(d_pre[2]), 32'd0);
        req_n = 4'b1011; step(1);
        check("pre_back_to2", 32'(d_own[0]), 32'd2);
        check("pre_pulse_one_cycle", 32'(d_pre[0]), 32'd0);

        // Preemption disabled: 1000 contended cycles
        req_n = 4'b1010; step(1000);
        check("nopre_b_own", 32'(d_own[1]), 32'd2);
        check("nopre_b_pulses", 32'(b_pre_seen), 32'd0);

        // Async reset mid-tenure: owner 3, tenure 9
        req_n = 4'b0111; step(1);
        check("ar_own3", 32'(d_own[0]), 32'd3);
        req_n = 4'b0110; step(9);
        check("ar_still3", 32'(d_own[0]), 32'd3);
        #1 reset_ = 1'b0;
        #1;
        check("ar_grnt_now", 32'(d_gnt[0]), 32'h0000000E);
        check("ar_owner_now", 32'(d_own[0]), 32'd0);
        check("ar_pre_now", 32'(d_pre[0]), 32'd0);
        @(negedge clk) reset_ = 1'b1;
        step(15);
        check("ar_cnt_restart_a", 32'(d_own[0]), 32'd0);
        check("ar_cnt_restart_c", 32'(d_own[2]), 32'd3);
        step(1);
        check("ar_a_switch", 32'(d_own[0]), 32'd3);
        check("ar_a_pulse", 32'(d_pre[0]), 32'd1);

        req_n = 4'hF; step(3);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Watchdog so the run always ends
    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
